vga_timing_driver: RTL
======================

Name: vga_timing_driver

Overview:
- Generates 640x480@60 Hz VGA timing (HSYNC/VSYNC) from the 25.175/25 MHz vga_clk.
- Issues pixel coordinates (pixel_xpos/pixel_ypos) one cycle ahead to the pixel-generation block, which returns registered 16-bit RGB565 pixel_data.
- Gates pixel_data onto the VGA RGB pins during active video and blanks it otherwise.
- Sits between the pixel-generation block and the board VGA connector; it is the coordinate-issuing, pixel-consuming end of that interface.

Parameters:
- H_SYNC, 10'd96, hsync pulse width in clocks
- H_BACK, 10'd48, horizontal back porch
- H_DISP, 10'd640, horizontal active pixels
- H_FRONT, 10'd16, horizontal front porch
- H_TOTAL, 10'd800, clocks per line (must equal the sum of the four above)
- V_SYNC, 10'd2, vsync width in lines
- V_BACK, 10'd33, vertical back porch lines
- V_DISP, 10'd480, active lines
- V_FRONT, 10'd10, vertical front porch lines
- V_TOTAL, 10'd525, lines per frame

Ports:
- vga_clk  input  1  pixel clock
- vga_rst_n  input  1  asynchronous active-low reset
- pixel_data  input  16  RGB565 from pixel generator, registered there, valid one cycle after the matching coordinate
- pixel_xpos  output  10  requested pixel column, 0..639
- pixel_ypos  output  10  requested pixel row, 0..479
- data_req  output  1  coordinate request valid
- vga_hs  output  1  horizontal sync, active low
- vga_vs  output  1  vertical sync, active low
- vga_en  output  1  active-video window
- vga_rgb  output  16  RGB565 to DAC/pins
- frame_end  output  1  one-cycle pulse on the last clock of each frame

Behaviour:
- **Reset and counters.** Reset is asynchronous, active-low, on vga_rst_n, with one clock, vga_clk.
  - h_cnt (10b) and v_cnt (10b) are registers; both clear to 0 on reset.
  - h_cnt increments every clock and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only when h_cnt == H_TOTAL-1, and wraps V_TOTAL-1 -> 0 at that same edge.
- **Output derivation.** All outputs are combinational functions of h_cnt/v_cnt plus pixel_data, so reset values follow from h_cnt = v_cnt = 0:
  - vga_hs = 0, vga_vs = 0
  - data_req = 0, vga_en = 0
  - pixel_xpos = 0, pixel_ypos = 0
  - vga_rgb = 0, frame_end = 0
- **Sync.**
  - vga_hs = 0 when h_cnt < H_SYNC, else 1.
  - vga_vs = 0 when v_cnt < V_SYNC, else 1.
- **Active video.**
  - v_act = (V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_DISP), i.e. lines 35..514.
  - vga_en = v_act AND (H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_DISP), i.e. h_cnt 144..783.
- **Request, 1-cycle lead.**
  - data_req = v_act AND (H_SYNC+H_BACK-1 <= h_cnt < H_SYNC+H_BACK+H_DISP-1), i.e. h_cnt 143..782.
  - pixel_xpos = h_cnt - (H_SYNC+H_BACK-1) when data_req, else 0.
  - pixel_ypos = v_cnt - (V_SYNC+V_BACK) when data_req, else 0.
  - Subtractions are 10-bit; they are only evaluated in range, so there is no wrap.
- **Pixel return.** Coordinate (x,y) issued at h_cnt = 143+x is returned by the generator on the next clock, when h_cnt = 144+x and vga_en = 1. vga_rgb = vga_en ? pixel_data : 16'h0000.
- **frame_end.** frame_end = 1 exactly when h_cnt == H_TOTAL-1 AND v_cnt == V_TOTAL-1.
- **Totals.**
  - Line = 800 clocks; frame = 420000 clocks.
  - Exactly 640 data_req cycles per active line and 480 active lines per frame.
- **Boundaries.**
  - pixel_data outside vga_en is ignored.
  - At the line wrap and the frame wrap, counters go to 0 in the same cycle; no extra idle cycle is inserted.
  - Reset asserted mid-frame immediately forces the counters, and therefore all outputs, to reset values.
  - On release, timing restarts at h_cnt = 0, v_cnt = 0, i.e. at the start of an hsync and vsync pulse.
- **Latches.** No latches. There is no state other than h_cnt and v_cnt.

Test Plan:
- **Sync timing.** Release reset, count clocks → vga_hs low for exactly 96 clocks then high for 704, repeating every 800; vga_vs low for exactly 1600 clocks (2 lines) per 420000-clock frame, starting at cycle 0.
- **First request.** Frame 0, line 35 → first data_req at h_cnt = 143 with xpos = 0, ypos = 0; last data_req on that line at h_cnt = 782 with xpos = 639; exactly 640 request cycles; none on lines 0–34 or 515–524.
- **Active-window edges.** vga_en rises at h_cnt = 144, line 35, and falls after h_cnt = 783, line 514; last request gives xpos = 639, ypos = 479; frame_end pulses once, at h_cnt = 799, v_cnt = 524.
- **Pixel pass-through.** Model a generator that registers pixel_data = {ypos[5:0], xpos[9:0]} → at every vga_en cycle vga_rgb equals {y[5:0], x[9:0]} for x = h_cnt-144, y = v_cnt-35; vga_rgb = 0 whenever vga_en = 0, even with pixel_data = 16'hFFFF.
- **Mid-frame reset.** Assert vga_rst_n = 0 at h_cnt = 400, v_cnt = 200, asynchronously between edges → all outputs are 0 immediately; after release, the first data_req occurs 35*800+143 = 28143 clocks later with xpos = 0, ypos = 0.
- **Multi-frame run.** Run 3 full frames → frame_end fires at cycles 419999, 839999 and 1259999 after release; no drift in sync or request positions between frames.

Source files
------------

// File: rtl/vga_timing_driver.sv
// rtl/vga_timing_driver.sv - 640x480@60 VGA timing generator with one-cycle-ahead pixel request
// Counters h_cnt/v_cnt are the only state; every output is decoded from them.
module vga_timing_driver #(
  parameter logic [9:0] H_SYNC  = 10'd96,
  parameter logic [9:0] H_BACK  = 10'd48,
  parameter logic [9:0] H_DISP  = 10'd640,
  parameter logic [9:0] H_FRONT = 10'd16,
  parameter logic [9:0] H_TOTAL = 10'd800,
  parameter logic [9:0] V_SYNC  = 10'd2,
  parameter logic [9:0] V_BACK  = 10'd33,
  parameter logic [9:0] V_DISP  = 10'd480,
  parameter logic [9:0] V_FRONT = 10'd10,
  parameter logic [9:0] V_TOTAL = 10'd525
) (
  input  logic        vga_clk,
  input  logic        vga_rst_n,
  input  logic [15:0] pixel_data,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        data_req,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_en,
  output logic [15:0] vga_rgb,
  output logic        frame_end
);

  localparam logic [9:0] H_ACT_BEG = H_SYNC + H_BACK;
  localparam logic [9:0] H_ACT_END = H_ACT_BEG + H_DISP;
  localparam logic [9:0] H_REQ_BEG = H_ACT_BEG - 10'd1;
  localparam logic [9:0] H_REQ_END = H_ACT_END - 10'd1;
  localparam logic [9:0] V_ACT_BEG = V_SYNC + V_BACK;
  localparam logic [9:0] V_ACT_END = V_ACT_BEG + V_DISP;

  // Porch widths only matter through the totals, so refuse inconsistent sets at elaboration.
  if (H_SYNC + H_BACK + H_DISP + H_FRONT != H_TOTAL) begin : g_bad_h_total
    $error("vga_timing_driver: horizontal timing does not sum to H_TOTAL");
  end
  if (V_SYNC + V_BACK + V_DISP + V_FRONT != V_TOTAL) begin : g_bad_v_total
    $error("vga_timing_driver: vertical timing does not sum to V_TOTAL");
  end

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;
  logic       v_act;
  logic       h_act;
  logic       h_req;

  assign h_last = (h_cnt == H_TOTAL - 10'd1);
  assign v_last = (v_cnt == V_TOTAL - 10'd1);

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign vga_hs    = (h_cnt >= H_SYNC);
  assign vga_vs    = (v_cnt >= V_SYNC);
  assign frame_end = h_last && v_last;

  assign v_act = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
  assign h_act = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
  // Request window leads the active window by one clock to cover the generator's register.
  assign h_req = (h_cnt >= H_REQ_BEG) && (h_cnt < H_REQ_END);

  assign vga_en     = v_act && h_act;
  assign data_req   = v_act && h_req;
  assign pixel_xpos = data_req ? (h_cnt - H_REQ_BEG) : 10'd0;
  assign pixel_ypos = data_req ? (v_cnt - V_ACT_BEG) : 10'd0;
  assign vga_rgb    = vga_en ? pixel_data : 16'h0000;

endmodule
